// File: rtl/cpu_mu0_delay0.sv
// MU0 accumulator CPU, two cycles per instruction (FETCH, EXEC), driving a
// single memory port whose read data is valid combinationally in the same cycle.
module cpu_mu0_delay0 (
    input  logic        clk,
    input  logic        rst,
    output logic        running,
    output logic [11:0] address,
    output logic        write,
    output logic        read,
    output logic [15:0] writedata,
    input  logic [15:0] readdata,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        EXEC   = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [3:0] OP_LDA = 4'd0;
    localparam logic [3:0] OP_STA = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_SUB = 4'd3;
    localparam logic [3:0] OP_JMP = 4'd4;
    localparam logic [3:0] OP_JGE = 4'd5;
    localparam logic [3:0] OP_JNE = 4'd6;

    state_t      state, state_n;
    logic [11:0] pc, pc_n;
    logic [15:0] ir, ir_n;
    logic [15:0] acc, acc_n;

    logic [3:0]  opcode;
    logic [11:0] operand;

    assign opcode  = ir[15:12];
    assign operand = ir[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= FETCH;
            pc    <= 12'd0;
            ir    <= 16'd0;
            acc   <= 16'd0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ir    <= ir_n;
            acc   <= acc_n;
        end
    end

    // Memory port: read and write are one-hot-or-idle strobes, never both high.
    // readdata is consumed on the same edge that ends the cycle raising read;
    // a write lands in memory on the edge that ends the cycle raising write.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        ir_n    = ir;
        acc_n   = acc;
        address = pc;
        read    = 1'b0;
        write   = 1'b0;

        case (state)
            FETCH: begin
                read    = 1'b1;
                ir_n    = readdata;
                pc_n    = pc + 12'd1;
                state_n = EXEC;
            end
            EXEC: begin
                state_n = FETCH;
                case (opcode)
                    OP_LDA: begin
                        address = operand;
                        read    = 1'b1;
                        acc_n   = readdata;
                    end
                    OP_STA: begin
                        address = operand;
                        write   = 1'b1;
                    end
                    OP_ADD: begin
                        address = operand;
                        read    = 1'b1;
                        acc_n   = acc + readdata;
                    end
                    OP_SUB: begin
                        address = operand;
                        read    = 1'b1;
                        acc_n   = acc - readdata;
                    end
                    OP_JMP: pc_n = operand;
                    OP_JGE: if (!acc[15]) pc_n = operand;
                    OP_JNE: if (acc != 16'd0) pc_n = operand;
                    // STP and every unassigned opcode stop the machine.
                    default: state_n = HALTED;
                endcase
            end
            default: begin
                state_n = HALTED;
            end
        endcase
    end

    assign running   = (state != HALTED);
    assign writedata = acc;
    assign dbg_state = state;

endmodule

// File: tb/tb_cpu_mu0_delay0.sv
// Bench for cpu_mu0_delay0: an instruction-level MU0 model predicts the full
// per-cycle bus trace and final memory image, which are checked against the DUT.
module tb_cpu_mu0_delay0;

    logic        clk;
    logic        rst;
    logic        running;
    logic [11:0] address;
    logic        write;
    logic        read;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic [1:0]  dbg_state;

    cpu_mu0_delay0 dut (
        .clk       (clk),
        .rst       (rst),
        .running   (running),
        .address   (address),
        .write     (write),
        .read      (read),
        .writedata (writedata),
        .readdata  (readdata),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- memory seen by the DUT ----------------
    logic [15:0] mem_ram [4096];
    assign readdata = read ? mem_ram[address] : 16'hDEAD;
    always @(posedge clk) begin
        if (write) mem_ram[address] = writedata;
    end

    // ---------------- scoreboard ----------------
    // Entry: {care_addr, care_strobe, running, read, write, address, writedata}
    localparam int W = 33;
    logic [W-1:0] exp_q[$];
    logic [15:0]  prog  [4096];
    logic [15:0]  m_mem [4096];
    int errors = 0;
    int checks = 0;

    function automatic logic [W-1:0] mk(input bit ca, input bit cs, input bit run,
                                        input bit rd, input bit wr,
                                        input logic [11:0] a, input logic [15:0] d);
        return {ca, cs, run, cs ? rd : 1'b0, cs ? wr : 1'b0, ca ? a : 12'd0, d};
    endfunction

    task automatic check_bus(input string tag, input int idx, input logic [W-1:0] e);
        logic [W-1:0] obs;
        obs = mk(e[32], e[31], running, read, write, address, writedata);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, idx, obs, e);
        end
    endtask

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, e);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic run_model(input int budget, output int halt_idx);
        logic [11:0] pc;
        logic [15:0] acc, ir;
        logic [11:0] s;
        bit halted;
        exp_q.delete();
        for (int i = 0; i < 4096; i++) m_mem[i] = prog[i];
        pc = 0; acc = 0; halted = 0; halt_idx = -1;
        while (exp_q.size() < budget) begin
            if (halted) begin
                if (exp_q.size() >= halt_idx + 3) break;
                exp_q.push_back(mk(1, 1, 0, 0, 0, pc, acc));
                continue;
            end
            exp_q.push_back(mk(1, 1, 1, 1, 0, pc, acc));
            ir = m_mem[pc];
            pc = pc + 12'd1;
            if (exp_q.size() >= budget) break;
            s = ir[11:0];
            case (ir[15:12])
                4'd0: begin exp_q.push_back(mk(1, 1, 1, 1, 0, s, acc)); acc = m_mem[s]; end
                4'd1: begin exp_q.push_back(mk(1, 1, 1, 0, 1, s, acc)); m_mem[s] = acc; end
                4'd2: begin exp_q.push_back(mk(1, 1, 1, 1, 0, s, acc)); acc = acc + m_mem[s]; end
                4'd3: begin exp_q.push_back(mk(1, 1, 1, 1, 0, s, acc)); acc = acc - m_mem[s]; end
                4'd4: begin exp_q.push_back(mk(0, 1, 1, 0, 0, 0, acc)); pc = s; end
                4'd5: begin exp_q.push_back(mk(0, 1, 1, 0, 0, 0, acc)); if ($signed(acc) >= 0) pc = s; end
                4'd6: begin exp_q.push_back(mk(0, 1, 1, 0, 0, 0, acc)); if (acc != 0) pc = s; end
                default: begin
                    exp_q.push_back(mk(0, 0, 1, 0, 0, 0, acc));
                    halted = 1;
                    halt_idx = exp_q.size();
                end
            endcase
        end
    endtask

    // ---------------- driver ----------------
    task automatic clear_prog();
        for (int i = 0; i < 4096; i++) prog[i] = 16'h0000;
    endtask

    task automatic run_test(input string tag, input int budget, input int abort_at,
                            output int dut_halt);
        int model_halt, idx, mism, first_bad;
        logic [W-1:0] e;
        bit aborted;
        run_model(budget, model_halt);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4096; i++) mem_ram[i] = prog[i];
        #1 check_bus({tag, "_reset"}, -1, mk(1, 1, 1, 1, 0, 12'd0, 16'd0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        idx = 0; dut_halt = -1; aborted = 0;
        while (exp_q.size() > 0) begin
            if (idx > 0) begin @(negedge clk); #1; end
            e = exp_q.pop_front();
            check_bus(tag, idx, e);
            if (dut_halt < 0 && running === 1'b0) dut_halt = idx;
            if (idx == abort_at) begin
                #2 rst = 1'b1;
                #1 check_bus({tag, "_abort"}, idx, mk(1, 1, 1, 1, 0, 12'd0, 16'd0));
                aborted = 1;
                break;
            end
            idx++;
        end
        if (!aborted) begin
            check_val({tag, "_halt_cycle"}, dut_halt, model_halt);
            @(posedge clk); #1;
            mism = 0; first_bad = -1;
            for (int i = 0; i < 4096; i++) begin
                if (mem_ram[i] !== m_mem[i]) begin
                    mism++;
                    if (first_bad < 0) first_bad = i;
                end
            end
            check_val({tag, "_mem_image"}, mism, 0);
            if (first_bad >= 0)
                $display("  %s first differing word at %h: %h vs model %h",
                         tag, first_bad, mem_ram[first_bad], m_mem[first_bad]);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int h;
        logic [15:0] v, orig;
        logic [15:0] jge_vals [3];
        rst = 1'b1;
        repeat (2) @(posedge clk);

        // Immediate halt.
        clear_prog(); prog[0] = 16'h7000;
        run_test("stp", 100, -1, h);
        check_val("stp_halt_at_2", h, 2);

        // Load/add/store.
        clear_prog();
        prog[0] = 16'h0010; prog[1] = 16'h2011; prog[2] = 16'h1012; prog[3] = 16'h7000;
        prog[16'h10] = 16'd5; prog[16'h11] = 16'd7;
        run_test("lda_add_sta", 100, -1, h);
        check_val("lda_add_sta_halt_at_8", h, 8);
        check_val("lda_add_sta_result", mem_ram[12'h012], 16'd12);

        // Countdown loop, ten iterations.
        clear_prog();
        prog[0] = 16'h0020; prog[1] = 16'h3021; prog[2] = 16'h6001; prog[3] = 16'h7000;
        prog[16'h20] = 16'd10; prog[16'h21] = 16'd1;
        run_test("countdown", 200, -1, h);
        check_val("countdown_halt_at_44", h, 44);

        // JGE sign cases.
        jge_vals[0] = 16'h8000; jge_vals[1] = 16'h7FFF; jge_vals[2] = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            clear_prog();
            prog[0] = 16'h0020; prog[1] = 16'h5004; prog[2] = 16'h1030; prog[3] = 16'h7000;
            prog[4] = 16'h1031; prog[5] = 16'h7000;
            prog[16'h20] = jge_vals[k];
            run_test($sformatf("jge_%0d", k), 100, -1, h);
            check_val($sformatf("jge_%0d_taken_marker", k), mem_ram[12'h031],
                      (k == 0) ? 16'h0000 : jge_vals[k]);
        end

        // Add/sub wrap.
        clear_prog();
        prog[0] = 16'h0020; prog[1] = 16'h2021; prog[2] = 16'h1030;
        prog[3] = 16'h0022; prog[4] = 16'h3021; prog[5] = 16'h1031; prog[6] = 16'h7000;
        prog[16'h20] = 16'h7FFF; prog[16'h21] = 16'h0001; prog[16'h22] = 16'h0000;
        run_test("wrap", 100, -1, h);
        check_val("wrap_add", mem_ram[12'h030], 16'h8000);
        check_val("wrap_sub", mem_ram[12'h031], 16'hFFFF);

        // Unassigned opcode halts like STP.
        clear_prog(); prog[0] = 16'hA123;
        run_test("illegal_op", 100, -1, h);
        check_val("illegal_op_halt_at_2", h, 2);

        // PC wraps from 0xFFF back to 0.
        clear_prog(); prog[0] = 16'h4FFF; prog[12'hFFF] = 16'h0010;
        run_test("pc_wrap", 24, -1, h);

        // Jump to self never halts.
        clear_prog(); prog[0] = 16'h4000;
        run_test("jmp_self", 40, -1, h);
        check_val("jmp_self_no_halt", h, -1);

        // Reset during a store's execute cycle suppresses the write.
        clear_prog();
        v = 16'($urandom); orig = ~v;
        prog[0] = 16'h0010; prog[1] = 16'h1011; prog[2] = 16'h7000;
        prog[16'h10] = v; prog[16'h11] = orig;
        run_test("sta_abort", 100, 3, h);
        @(posedge clk); #1;
        check_val("sta_abort_target", mem_ram[12'h011], orig);

        // Reset while halted restarts from 0.
        clear_prog(); prog[0] = 16'h0010; prog[1] = 16'h7000; prog[16'h10] = 16'($urandom);
        run_test("halt_a", 50, -1, h);
        run_test("halt_restart", 50, -1, h);

        // Random programs.
        for (int t = 0; t < 8; t++) begin
            int r;
            clear_prog();
            for (int i = 0; i < 32; i++) begin
                r = $urandom_range(0, 15);
                prog[i] = {(r < 14) ? 4'(r % 7) : 4'd7, 6'd0, 6'($urandom_range(0, 63))};
            end
            for (int i = 32; i < 64; i++) prog[i] = 16'($urandom);
            run_test($sformatf("rand_%0d", t), 300, -1, h);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
